// File: rtl/divider_pipe.sv
// divider_pipe
//   Fully pipelined restoring integer divider. DW division stages, each
//   resolving one quotient bit, followed by an output register. The whole
//   pipe advances together whenever the output slot is empty or is being
//   accepted, so a stalled consumer freezes every stage in place.
//   A user tag and the divide-by-zero flag ride alongside each operation.
//
//   Build option: define DIV_SIGNED_EN to add the in_signed port and
//   two's-complement operation (magnitudes at entry, sign fix-up at exit).
module divider_pipe #(
  parameter int DW    = 8,
  parameter int VW    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_dvd,
  input  logic [VW-1:0]    in_dvs,
  input  logic [TAG_W-1:0] in_tag,
`ifdef DIV_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_quo,
  output logic [VW-1:0]    out_rem,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz
);

  // Per-stage payload. dq starts as the dividend; each stage shifts one
  // dividend bit out of the top and one quotient bit in at the bottom, so
  // after DW stages it holds the full quotient.
  typedef struct packed {
    logic [DW-1:0]    dq;
    logic [VW-1:0]    rem;
    logic [VW-1:0]    dvs;
    logic [TAG_W-1:0] tag;
    logic             dz;
`ifdef DIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif
  } stage_t;

  // One restoring step: bring down the next dividend bit, subtract the
  // divisor if it fits. The remainder stays below the divisor, so VW bits
  // always hold it.
  function automatic stage_t div_step(input stage_t s);
    stage_t     n;
    logic [VW:0] t;
    logic [VW:0] diff;
    logic        q;
    n    = s;
    t    = {s.rem, s.dq[DW-1]};
    diff = t - {1'b0, s.dvs};
    q    = (t >= {1'b0, s.dvs});
    n.rem = q ? diff[VW-1:0] : t[VW-1:0];
    n.dq  = (s.dq << 1) | DW'(q);
    return n;
  endfunction

  logic             adv;
  stage_t           in_stage;
  stage_t           last_step;
  logic [DW-1:0]    res_quo;
  logic [VW-1:0]    res_rem;

  stage_t           stage_q [DW];
  stage_t           stage_d [DW];
  logic [DW-1:0]    vld_q;
  logic [DW-1:0]    vld_d;

  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_quo_q,   out_quo_d;
  logic [VW-1:0]    out_rem_q,   out_rem_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             out_dz_q,    out_dz_d;

`ifdef DIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  assign dvd_neg = in_signed && in_dvd[DW-1];
  assign dvs_neg = in_signed && in_dvs[VW-1];
`endif

  // The pipe moves only when the output slot can take a new value.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Operand capture: build the stage-0 payload (magnitudes in signed mode).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a latch behind.
    in_stage     = '0;
    in_stage.dq  = in_dvd;
    in_stage.rem = '0;
    in_stage.dvs = in_dvs;
    in_stage.tag = in_tag;
    in_stage.dz  = (in_dvs == '0);
`ifdef DIV_SIGNED_EN
    in_stage.neg_r = dvd_neg;
    in_stage.neg_q = dvd_neg ^ dvs_neg;
    if (dvd_neg) in_stage.dq  = -in_dvd;
    if (dvs_neg) in_stage.dvs = -in_dvs;
`endif
  end

  // Final step plus result formatting: sign fix-up, then the divide-by-zero
  // override, which wins in both signed and unsigned mode.
  always_comb begin
    last_step = div_step(stage_q[DW-1]);
    res_quo   = last_step.dq;
    res_rem   = last_step.rem;
`ifdef DIV_SIGNED_EN
    if (last_step.neg_q) res_quo = -last_step.dq;
    if (last_step.neg_r) res_rem = -last_step.rem;
`endif
    if (last_step.dz) begin
      res_quo = '1;
      res_rem = '0;
    end
  end

  // Next state: shift every stage forward on adv, hold otherwise; flush
  // drops all in-flight work including a result waiting at the output.
  always_comb begin
    vld_d       = vld_q;
    stage_d     = stage_q;
    out_valid_d = out_valid_q;
    out_quo_d   = out_quo_q;
    out_rem_d   = out_rem_q;
    out_tag_d   = out_tag_q;
    out_dz_d    = out_dz_q;

    if (adv) begin
      vld_d[0]   = in_valid;
      stage_d[0] = in_stage;
      for (int i = 1; i < DW; i++) begin
        vld_d[i]   = vld_q[i-1];
        stage_d[i] = div_step(stage_q[i-1]);
      end
      out_valid_d = vld_q[DW-1];
      if (vld_q[DW-1]) begin
        out_quo_d = res_quo;
        out_rem_d = res_rem;
        out_tag_d = last_step.tag;
        out_dz_d  = last_step.dz;
      end
    end

    if (flush) begin
      vld_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  // Stage payload registers.
  always_ff @(posedge clk) begin
    // NOTE: payload flops carry no reset; a stage whose valid bit is 0 is
    // never observed, so only the valid bits need a known value.
    stage_q <= stage_d;
  end

  // Stage valid bits and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignment so every flop updates from
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      out_tag_q   <= '0;
      out_dz_q    <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_quo_q   <= out_quo_d;
      out_rem_q   <= out_rem_d;
      out_tag_q   <= out_tag_d;
      out_dz_q    <= out_dz_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_quo   = out_quo_q;
  assign out_rem   = out_rem_q;
  assign out_tag   = out_tag_q;
  assign out_dz    = out_dz_q;

`ifndef SYNTHESIS
  // A presented but unaccepted result must not change or vanish unless flushed.
  hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !out_ready && !flush) |=>
      (out_valid_q && $stable({out_quo_q, out_rem_q, out_tag_q, out_dz_q})));
`endif

endmodule

// File: tb/tb_divider_pipe.sv
// tb_divider_pipe: scoreboard bench for divider_pipe. Accepted operations push
// their expected result (arithmetic reference or fixed vector); an independent
// monitor pops and compares whenever a result is handed over.
module tb_divider_pipe;
  localparam int DW    = 8;
  localparam int VW    = 4;
  localparam int TAG_W = 4;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_dvd = '0;
  logic [VW-1:0]    in_dvs = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_sgn = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_quo;
  logic [VW-1:0]    out_rem;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;

  divider_pipe #(.DW(DW), .VW(VW), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dvd    (in_dvd),
    .in_dvs    (in_dvs),
    .in_tag    (in_tag),
`ifdef DIV_SIGNED_EN
    .in_signed (in_sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quo   (out_quo),
    .out_rem   (out_rem),
    .out_tag   (out_tag),
    .out_dz    (out_dz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]    quo;
    logic [VW-1:0]    rem;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division. SV '/' truncates toward zero and '%'
  // follows the dividend's sign, matching the signed rules directly.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                 input logic [TAG_W-1:0] t, input logic s);
    exp_t e;
    int   na, nb, q, r;
    e.tag = t;
    e.dz  = (b == '0);
    na = int'(a);
    nb = int'(b);
    if (SIGNED_BUILD && s) begin
      na = int'($signed(a));
      nb = int'($signed(b));
    end
    if (nb == 0) begin
      e.quo = '1;
      e.rem = '0;
    end else begin
      q = na / nb;
      r = na % nb;
      e.quo = DW'(q);
      e.rem = VW'(r);
    end
    return e;
  endfunction

  // Monitor: handshake rule, hold-under-stall, and in-order scoreboard pops.
  exp_t prev_out;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      exp_t e;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", {out_quo, out_rem, out_tag, out_dz}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got quo=0x%0h tag=0x%0h, expected no output (t=%0t)",
                   out_quo, out_tag, $time);
        end else begin
          e = sb.pop_front();
          check("res_quo", out_quo, e.quo);
          check("res_rem", out_rem, e.rem);
          check("res_tag", out_tag, e.tag);
          check("res_dz",  out_dz,  e.dz);
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      prev_out   = {out_quo, out_rem, out_tag, out_dz};
    end
  end

  // One clock of stimulus; called just after a rising edge, returns just
  // after the next one. The expected result is pushed only on a real transfer.
  task automatic cycle(input logic v, input logic [DW-1:0] a, input logic [VW-1:0] b,
                       input logic [TAG_W-1:0] t, input logic s, input logic ordy,
                       input logic fl, input logic use_e, input exp_t e_in);
    exp_t e;
    in_valid  = v;
    in_dvd    = a;
    in_dvs    = b;
    in_tag    = t;
    in_sgn    = s;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (v && in_ready && !fl) begin
      if (use_e) e = e_in;
      else       e = model(a, b, t, s);
      sb.push_back(e);
    end
    @(posedge clk);
    if (fl) sb.delete();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic [TAG_W-1:0] t);
    cycle(1'b1, a, b, t, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic send_e(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic [TAG_W-1:0] t,
                        input logic s, input logic [DW-1:0] q, input logic [VW-1:0] r, input logic dz);
    exp_t e;
    e.quo = q;
    e.rem = r;
    e.tag = t;
    e.dz  = dz;
    cycle(1'b1, a, b, t, s, 1'b1, 1'b0, 1'b1, e);
  endtask

  task automatic send_rand(input logic ordy);
    cycle(1'b1, DW'($urandom), VW'($urandom_range(1, (1 << VW) - 1)), TAG_W'($urandom),
          1'b0, ordy, 1'b0, 1'b0, '0);
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_quo",   out_quo,   '0);
    check("rst_out_rem",   out_rem,   '0);
    check("rst_out_tag",   out_tag,   '0);
    check("rst_out_dz",    out_dz,    1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_quo",   out_quo,   '0);
    check("reset_out_rem",   out_rem,   '0);
    check("reset_out_tag",   out_tag,   '0);
    check("reset_out_dz",    out_dz,    1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1'b1);

    // Single op and its latency
    send_e(8'd200, 4'd7, 4'd3, 1'b0, 8'd28, 4'd4, 1'b0);
    idle(DW - 1);
    check("latency_not_early", out_valid, 1'b0);
    idle(1);
    check("latency_valid", out_valid, 1'b1);
    check("lat_quo", out_quo, 8'd28);
    check("lat_rem", out_rem, 4'd4);
    check("lat_tag", out_tag, 4'd3);
    check("lat_dz",  out_dz,  1'b0);
    idle(2);

    // Back-to-back ops give back-to-back results
    send_e(8'd255, 4'd15, 4'd4, 1'b0, 8'd17, 4'd0, 1'b0);
    send_e(8'd17,  4'd3,  4'd5, 1'b0, 8'd5,  4'd2, 1'b0);
    send_e(8'd0,   4'd1,  4'd6, 1'b0, 8'd0,  4'd0, 1'b0);
    send_e(8'd9,   4'd9,  4'd7, 1'b0, 8'd1,  4'd0, 1'b0);
    idle(DW - 3);
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_tag", out_tag, TAG_W'(4 + i));
      idle(1);
    end
    idle(2);

    // Full pipe with 5 cycles of backpressure, inputs still offered
    for (int i = 0; i < DW + 2; i++) send_rand(1'b1);
    for (int i = 0; i < 5; i++) begin
      send_rand(1'b0);
      check("stall_in_ready", in_ready, 1'b0);
    end
    idle(DW + 4);
    check("stall_drained", sb.size(), 0);

    // Divide by zero, then a normal op
    send_e(8'd5, 4'd0, 4'd9,  1'b0, 8'hFF, 4'd0, 1'b1);
    send_e(8'd6, 4'd2, 4'd10, 1'b0, 8'd3,  4'd0, 1'b0);
    idle(DW + 2);

    // Flush with 3 ops in flight and a 4th offered
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    cycle(1'b1, 8'd77, 4'd5, 4'd11, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("flush_out_valid", out_valid, 1'b0);
    idle(DW + 2);

    // Flush beats a stalled output
    for (int i = 0; i < DW + 2; i++) send_rand(1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("flush_stall_out_valid", out_valid, 1'b0);
    idle(DW + 2);

`ifdef DIV_SIGNED_EN
    // Signed vectors
    send_e(8'h9C, 4'd7,  4'd1, 1'b1, 8'hF2, 4'hE, 1'b0);
    send_e(8'h80, 4'hF,  4'd2, 1'b1, 8'h80, 4'h0, 1'b0);
    send_e(8'h9C, 4'd0,  4'd3, 1'b1, 8'hFF, 4'h0, 1'b1);
    send_e(8'h9C, 4'd7,  4'd4, 1'b0, 8'd22, 4'd2, 1'b0);
    idle(DW + 2);
`endif

    // Randomized traffic with stalls, occasional flush and one reset pulse
    for (int i = 0; i < 3000; i++) begin
      logic [VW-1:0] b;
      if (i == 1500) reset_pulse();
      b = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
      cycle($urandom_range(0, 3) != 0, DW'($urandom), b, TAG_W'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
            1'b0, '0);
    end

    idle(DW + 4);
    check("final_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
